logical_eq_sequencer: RTL and testbench
=======================================

# logical_eq_sequencer

Sequences multi-word equality comparisons through a single shared `LogicalEQ` comparator. A transaction declares a word count, streams that many operand pairs over a valid/ready channel, and returns one registered result: overall equality and the index of the first mismatching word. The block sits between a descriptor/stream source and the consumer of compare results, so wide or variable-length operands can be compared with one N-bit comparator.

## Interface
- `MODEL`, "Structural": passed unchanged to the `LogicalEQ` instance ("Structural", "Behavioral", "DataFlow").
- `N`, 8: operand word width in bits.
- `LEN_W`, 8: width of the word count and the mismatch index. Maximum transaction length is 2^LEN_W−1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start_valid`  in  1  transaction request.
- `start_ready`  out  1  block can accept a request.
- `start_len`  in  LEN_W  number of word pairs in the transaction.
- `op_valid`  in  1  operand pair valid.
- `op_ready`  out  1  operand pair accepted this cycle.
- `op_a`  in  N  operand A word.
- `op_b`  in  N  operand B word.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_eq`  out  1  1 = all words equal.
- `res_idx`  out  LEN_W  index of the first mismatching word; 0 when `res_eq`=1.

## Operation
- A handshake completes when valid and ready are both high at a rising edge. Once valid is raised it is held with stable data until the handshake completes.
- States:
  - IDLE: `start_ready`=1.
    - Start with `start_len`=0: go to DONE with `res_eq`=1, `res_idx`=0.
    - Start with `start_len`>0: latch the length, clear the counter and mismatch flag, go to RUN.
  - RUN: `op_ready`=1. On each operand handshake:
    - `LogicalEQ` compares `op_a`/`op_b` combinationally.
    - If the words differ and no earlier mismatch was recorded, set the mismatch flag and capture the counter into `res_idx`.
    - Increment the counter.
    - On the handshake where counter = len−1, go to DONE.
  - DONE: `res_valid`=1, with `res_eq` = NOT mismatch flag. On the result handshake, go to IDLE.
- There is no early exit. All `len` words are consumed even after a mismatch, so the stream stays aligned.
- `start_ready`, `op_ready` and `res_valid` are decoded from the state only; none depends combinationally on an input valid or ready.
- The counter is LEN_W bits and cannot wrap, because len ≤ 2^LEN_W−1.

## Timing
- Reset values: state IDLE, `start_ready`=1, `op_ready`=0, `res_valid`=0, `res_eq`=1, `res_idx`=0, counter 0, mismatch flag 0.
- Reset asserted mid-transaction aborts it immediately. Partial results are discarded and any pending result is dropped.
- Start handshake at cycle t: `op_ready`=1 from t+1.
- Throughput is one word per cycle while `op_valid` is held high. Gaps in `op_valid` stall the transaction with no state change.
- Last operand handshake at cycle t: `res_valid`=1 from t+1. Minimum transaction length is len+2 cycles from start handshake to result handshake. A zero-length transaction takes 2 cycles.
- `res_eq` and `res_idx` hold stable while `res_valid`=1 and `res_ready`=0.
- Back-to-back transactions: the next start can be accepted the cycle after the result handshake.
- `op_valid` asserted in IDLE or DONE is ignored (`op_ready`=0).

## Structure
- Package `logical_eq_sequencer_pkg` holds the state enum typedef (IDLE, RUN, DONE) and localparams for state encoding.
- Sub-module: exactly one `LogicalEQ` instance, `u_LogicalEQ`, with `MODEL` and `N` passed through. No other sub-modules.
- Counter, length register, mismatch flag and result registers live in the top module.

## Test plan
- len=4, all pairs equal (0x11/0x11 … 0x44/0x44) -> `res_eq`=1, `res_idx`=0, `res_valid` exactly 1 cycle after the 4th handshake.
- len=5, mismatches at words 2 and 3 (0xA5/0xA4, 0x00/0xFF) -> `res_eq`=0, `res_idx`=2, and all 5 words are still consumed.
- len=0 -> no `op_ready` pulse, `res_valid` on the next cycle, `res_eq`=1, `res_idx`=0.
- len=3 with `op_valid` toggling every other cycle, then `res_ready` held low for 4 cycles -> result held stable, `start_ready`=0 until the result handshake, next start accepted 1 cycle later.
- `rst_n` pulsed low after word 1 of a len=6 transaction containing a mismatch -> state IDLE with all reset values immediately. A following len=2 equal transaction gives `res_eq`=1.
- len=255 (LEN_W=8) with the single mismatch at word 254 -> `res_eq`=0, `res_idx`=254, no counter wrap.

Source files
------------

// File: rtl/logical_eq_sequencer_pkg.sv
// Shared types for the multi-word equality sequencer: the control state
// enumeration and its encoding.
package logical_eq_sequencer_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

endpackage : logical_eq_sequencer_pkg

// File: rtl/logical_eq_sequencer_logicaleq.sv
// N-bit combinational equality comparator with selectable implementation
// style; all styles produce the same function eq = (a == b).
module LogicalEQ #(
    parameter string MODEL = "Structural",
    parameter int    N     = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);

    if (MODEL == "Structural") begin : g_structural
        logic [N-1:0] bit_eq_s;
        logic [N:0]   chain_s;

        assign chain_s[0] = 1'b1;
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign bit_eq_s[i]  = ~(a[i] ^ b[i]);
            assign chain_s[i+1] = chain_s[i] & bit_eq_s[i];
        end
        assign eq = chain_s[N];
    end else if (MODEL == "Behavioral") begin : g_behavioral
        logic eq_s;

        // Whole-word compare.
        always_comb begin
            eq_s = 1'b0;
            if (a == b) begin
                eq_s = 1'b1;
            end else begin
                eq_s = 1'b0;
            end
        end
        assign eq = eq_s;
    end else begin : g_dataflow
        // "DataFlow" and any unrecognised name use the reduction form.
        assign eq = ~|(a ^ b);
    end

endmodule : LogicalEQ

// File: rtl/logical_eq_sequencer.sv
// Streams a counted sequence of operand word pairs through one shared
// comparator and returns overall equality plus the first mismatching index.
module logical_eq_sequencer
    import logical_eq_sequencer_pkg::*;
#(
    parameter string MODEL = "Structural",
    parameter int    N     = 8,
    parameter int    LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] start_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [N-1:0]     op_a,
    input  logic [N-1:0]     op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_eq,
    output logic [LEN_W-1:0] res_idx
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] res_idx_r;
    logic             mis_r;

    logic             word_eq_s;
    logic             start_hs_s;
    logic             op_hs_s;
    logic             res_hs_s;
    logic             last_word_s;
    logic             zero_len_s;

    LogicalEQ #(
        .MODEL (MODEL),
        .N     (N)
    ) u_LogicalEQ (
        .a  (op_a),
        .b  (op_b),
        .eq (word_eq_s)
    );

    // Handshakes only use state-decoded readies, so there is no input-to-ready path.
    assign start_hs_s  = start_valid & start_ready;
    assign op_hs_s     = op_valid & op_ready;
    assign res_hs_s    = res_valid & res_ready;
    assign last_word_s = (cnt_r == (len_r - LEN_ONE));
    assign zero_len_s  = (start_len == LEN_ZERO);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_hs_s) begin
                    if (zero_len_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (op_hs_s && last_word_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Channel strobes decoded from the registered state only.
    always_comb begin
        start_ready = 1'b0;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_ready = 1'b1;
            end
            ST_RUN: begin
                op_ready = 1'b1;
            end
            ST_DONE: begin
                res_valid = 1'b1;
            end
            default: begin
                start_ready = 1'b0;
                op_ready    = 1'b0;
                res_valid   = 1'b0;
            end
        endcase
    end

    // Length, word counter, mismatch flag and first-mismatch index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r     <= LEN_ZERO;
            cnt_r     <= LEN_ZERO;
            mis_r     <= 1'b0;
            res_idx_r <= LEN_ZERO;
        end else if (start_hs_s) begin
            len_r     <= start_len;
            cnt_r     <= LEN_ZERO;
            mis_r     <= 1'b0;
            res_idx_r <= LEN_ZERO;
        end else if (op_hs_s) begin
            // Every word is consumed even after a mismatch; only the first one is recorded.
            cnt_r <= cnt_r + LEN_ONE;
            if (!word_eq_s && !mis_r) begin
                mis_r     <= 1'b1;
                res_idx_r <= cnt_r;
            end else begin
                mis_r     <= mis_r;
                res_idx_r <= res_idx_r;
            end
        end else begin
            len_r     <= len_r;
            cnt_r     <= cnt_r;
            mis_r     <= mis_r;
            res_idx_r <= res_idx_r;
        end
    end

    assign res_eq  = ~mis_r;
    assign res_idx = res_idx_r;

endmodule : logical_eq_sequencer

// File: tb/tb_logical_eq_sequencer.sv
// Self-checking bench for logical_eq_sequencer: directed vector table,
// reset-abort sequence and randomized transactions against a reference model.
module tb_logical_eq_sequencer;

    localparam int N     = 8;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [LEN_W-1:0] start_len;
    logic             op_valid;
    logic             op_ready;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             res_valid;
    logic             res_ready;
    logic             res_eq;
    logic [LEN_W-1:0] res_idx;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int opr_cnt = 0;
    int viol = 0;

    logic [N-1:0] wa [0:255];
    logic [N-1:0] wb [0:255];

    typedef struct {
        int         len;
        int         m1;
        int         m2;
        int         gap;
        int         hold;
        logic       exp_eq;
        logic [7:0] exp_idx;
    } vec_t;

    vec_t vecs [8];

    logical_eq_sequencer #(
        .MODEL ("Structural"),
        .N     (N),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_len   (start_len),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_eq      (res_eq),
        .res_idx     (res_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (op_valid && op_ready) hs_cnt++;
        if (op_ready) opr_cnt++;
    end

    // The three channel strobes are mutually exclusive in every state.
    always @(negedge clk) begin
        if (rst_n && ((op_ready && start_ready) || (op_ready && res_valid) ||
                      (start_ready && res_valid))) viol++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int len, input int gap, input int hold,
                           input logic exp_eq, input logic [7:0] exp_idx, input string tag);
        int b;
        b = 0;
        while (!start_ready && b < 50) begin
            @(posedge clk); #1; b++;
        end
        chk({tag, " start_ready"}, start_ready, 1);
        hs_cnt = 0;
        opr_cnt = 0;
        start_valid = 1'b1;
        start_len = LEN_W'(len);
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk({tag, " start_ready low"}, start_ready, 0);
        if (len == 0) begin
            chk({tag, " zero-len op_ready"}, op_ready, 0);
        end else begin
            chk({tag, " op_ready after start"}, op_ready, 1);
            for (int i = 0; i < len; i++) begin
                if (gap != 0 && i > 0) begin
                    op_valid = 1'b0;
                    @(posedge clk); #1;
                end
                op_a = wa[i];
                op_b = wb[i];
                op_valid = 1'b1;
                if (i == len - 1) chk({tag, " res_valid early"}, res_valid, 0);
                b = 0;
                while (!op_ready && b < 50) begin
                    @(posedge clk); #1; b++;
                end
                if (!op_ready) chk({tag, " op_ready timeout"}, op_ready, 1);
                @(posedge clk); #1;
            end
            op_valid = 1'b0;
        end
        chk({tag, " res_valid latency"}, res_valid, 1);
        chk({tag, " words consumed"}, hs_cnt, len);
        if (len == 0) chk({tag, " op_ready pulses"}, opr_cnt, 0);
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold res_valid"}, res_valid, 1);
            chk({tag, " hold res_eq"}, res_eq, exp_eq);
            chk({tag, " hold res_idx"}, res_idx, exp_idx);
            chk({tag, " hold start_ready"}, start_ready, 0);
        end
        res_ready = 1'b1;
        chk({tag, " res_eq"}, res_eq, exp_eq);
        chk({tag, " res_idx"}, res_idx, exp_idx);
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, " res_valid cleared"}, res_valid, 0);
        chk({tag, " start_ready next"}, start_ready, 1);
    endtask

    task automatic fill(input int len, input int m1, input int m2);
        for (int i = 0; i < 256; i++) begin
            wa[i] = N'((i + 1) * 17);
            wb[i] = wa[i];
        end
        if (m1 >= 0) wb[m1] = wa[m1] ^ 8'h01;
        if (m2 >= 0) wb[m2] = ~wa[m2];
        if (len < 0) wa[0] = wa[0];
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " start_ready"}, start_ready, 1);
        chk({tag, " op_ready"}, op_ready, 0);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " res_eq"}, res_eq, 1);
        chk({tag, " res_idx"}, res_idx, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        start_len = '0;
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        res_ready = 1'b0;

        vecs[0] = '{len: 4,   m1: -1,  m2: -1, gap: 0, hold: 0, exp_eq: 1'b1, exp_idx: 8'd0};
        vecs[1] = '{len: 5,   m1: 2,   m2: 3,  gap: 0, hold: 0, exp_eq: 1'b0, exp_idx: 8'd2};
        vecs[2] = '{len: 0,   m1: -1,  m2: -1, gap: 0, hold: 0, exp_eq: 1'b1, exp_idx: 8'd0};
        vecs[3] = '{len: 3,   m1: -1,  m2: -1, gap: 1, hold: 4, exp_eq: 1'b1, exp_idx: 8'd0};
        vecs[4] = '{len: 3,   m1: 0,   m2: -1, gap: 1, hold: 2, exp_eq: 1'b0, exp_idx: 8'd0};
        vecs[5] = '{len: 1,   m1: 0,   m2: -1, gap: 0, hold: 0, exp_eq: 1'b0, exp_idx: 8'd0};
        vecs[6] = '{len: 255, m1: 254, m2: -1, gap: 0, hold: 1, exp_eq: 1'b0, exp_idx: 8'd254};
        vecs[7] = '{len: 7,   m1: 6,   m2: 2,  gap: 0, hold: 0, exp_eq: 1'b0, exp_idx: 8'd2};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("in reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("after reset");

        // Directed vector table; vector 1 uses the A5/A4, 00/FF word pairs.
        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].len, vecs[v].m1, vecs[v].m2);
            if (v == 1) begin
                wa[2] = 8'hA5; wb[2] = 8'hA4;
                wa[3] = 8'h00; wb[3] = 8'hFF;
            end
            if (v == 0) begin
                for (int i = 0; i < 4; i++) begin
                    wa[i] = N'((i + 1) * 17);
                    wb[i] = wa[i];
                end
            end
            run_txn(vecs[v].len, vecs[v].gap, vecs[v].hold,
                    vecs[v].exp_eq, vecs[v].exp_idx, $sformatf("vec%0d", v));
        end

        // Reset asserted after word 0 of a len=6 transaction that mismatched at word 0.
        fill(6, 0, -1);
        chk("rst start_ready", start_ready, 1);
        start_valid = 1'b1;
        start_len = 8'd6;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op_a = wa[0];
        op_b = wb[0];
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("rst mid eq flag", res_eq, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("post abort");
        fill(2, -1, -1);
        run_txn(2, 0, 0, 1'b1, 8'd0, "after abort");

        // Randomized transactions against a first-mismatch reference model.
        for (int t = 0; t < 25; t++) begin
            int len;
            logic eq_m;
            logic [7:0] idx_m;
            len = int'($urandom_range(0, 20));
            for (int i = 0; i < len; i++) begin
                wa[i] = N'($urandom);
                wb[i] = ($urandom_range(0, 4) == 0) ? N'($urandom) : wa[i];
            end
            eq_m = 1'b1;
            idx_m = 8'd0;
            for (int i = 0; i < len; i++) begin
                if (eq_m && wa[i] != wb[i]) begin
                    eq_m = 1'b0;
                    idx_m = 8'(i);
                end
            end
            run_txn(len, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    eq_m, idx_m, $sformatf("rand%0d", t));
        end

        chk("strobe exclusivity", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_logical_eq_sequencer
